// File: rtl/sim_ctrl_responder.sv
// Simulation-control device on the core data bus: exit code, console FIFO,
// cycle counter and done/pass/timeout flags for the top-level bench.
module sim_ctrl_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          TIMEOUT    = 10000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_req_ready,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_con_valid,
    output logic [7:0]  o_con_data,
    input  logic        i_con_ready,
    output logic        o_done,
    output logic        o_pass,
    output logic [30:0] o_exit_code,
    output logic        o_timeout,
    output logic [31:0] o_cycles
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALT
    } state_t;

    state_t state, state_n;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, free;

    logic [31:0] tohost_q;
    logic [31:0] cycles, cyc_nxt;
    logic [30:0] exit_q;
    logic        pass_q, timeout_q;
    logic [31:0] rdata_n;

    logic       hit, full, empty;
    logic [1:0] off;
    logic       con_wr, accept, push, pop;
    logic       tohost_wr, exit_req, hit_timeout;
    logic       latch_exit, set_timeout;
    logic       unused_addr;

    assign hit   = (i_req_addr[31:4] == BASE_ADDR[31:4]);
    assign off   = i_req_addr[3:2];
    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign free  = CW'(FIFO_DEPTH) - count;

    assign unused_addr = ^i_req_addr[1:0];

    // Only a console write into a full FIFO stalls the core.
    assign con_wr      = i_req_valid & i_req_we & hit & (off == 2'd1);
    assign o_req_ready = !(full && con_wr);
    assign accept      = i_req_valid & o_req_ready;
    assign push        = accept & con_wr;
    assign pop         = !empty & i_con_ready;

    assign tohost_wr   = accept & i_req_we & hit & (off == 2'd0);
    assign exit_req    = tohost_wr & i_req_wdata[0];

    assign cyc_nxt     = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;
    assign hit_timeout = (cyc_nxt == 32'(TIMEOUT - 1));

    always_comb begin
        state_n     = state;
        latch_exit  = 1'b0;
        set_timeout = 1'b0;
        unique case (state)
            RUN: begin
                if (exit_req) begin
                    state_n    = DRAIN;
                    latch_exit = 1'b1;
                end else if (hit_timeout) begin
                    state_n     = HALT;
                    set_timeout = 1'b1;
                end
            end
            DRAIN: begin
                if (empty) begin
                    state_n = HALT;
                end else if (hit_timeout) begin
                    state_n     = HALT;
                    set_timeout = 1'b1;
                end
            end
            HALT:    state_n = HALT;
            default: state_n = RUN;
        endcase
    end

    always_comb begin
        rdata_n = 32'hDEAD_BEEF;
        if (i_req_we) begin
            rdata_n = '0;
        end else if (hit) begin
            unique case (off)
                2'd0: rdata_n = tohost_q;
                2'd1: rdata_n = 32'(free);
                2'd2: rdata_n = cycles;
                2'd3: rdata_n = {28'b0, timeout_q, full, empty,
                                 state == HALT};
                default: rdata_n = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= RUN;
            tohost_q    <= '0;
            cycles      <= '0;
            exit_q      <= '0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
        end else begin
            state       <= state_n;
            cycles      <= cyc_nxt;
            o_rsp_valid <= accept;
            o_rsp_rdata <= accept ? rdata_n : '0;
            if (tohost_wr) begin
                tohost_q <= i_req_wdata;
            end
            if (latch_exit) begin
                exit_q <= i_req_wdata[31:1];
                pass_q <= (i_req_wdata[31:1] == '0);
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
                pass_q    <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_req_wdata[7:0];
        end
    end

    assign o_con_valid = !empty;
    assign o_con_data  = empty ? 8'h00 : mem[rd_ptr];
    assign o_done      = (state == HALT);
    assign o_pass      = o_done & pass_q;
    assign o_exit_code = exit_q;
    assign o_timeout   = timeout_q;
    assign o_cycles    = cycles;

endmodule

// File: tb/tb_sim_ctrl_responder.sv
// Scoreboard bench for sim_ctrl_responder: bus responses and console
// bytes are predicted at acceptance and compared when the DUT emits them.
module tb_sim_ctrl_responder;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 8;
    localparam int          TMO   = 10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        con_ready = 1'b0;
    logic        req_ready, rsp_valid, con_valid;
    logic [31:0] rsp_rdata, cycles;
    logic [7:0]  con_data;
    logic        done, pass, timeout;
    logic [30:0] exit_code;

    sim_ctrl_responder #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT   (TMO)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req_valid(req_valid),
        .i_req_we   (req_we),
        .i_req_addr (req_addr),
        .i_req_wdata(req_wdata),
        .o_req_ready(req_ready),
        .o_rsp_valid(rsp_valid),
        .o_rsp_rdata(rsp_rdata),
        .o_con_valid(con_valid),
        .o_con_data (con_data),
        .i_con_ready(con_ready),
        .o_done     (done),
        .o_pass     (pass),
        .o_exit_code(exit_code),
        .o_timeout  (timeout),
        .o_cycles   (cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          edge_no;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [7:0]  con_q[$];
    rsp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int          ecnt = 0;
    logic [31:0] tcyc;

    always @(posedge clk) ecnt <= ecnt + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) tcyc <= '0;
        else if (tcyc != 32'hFFFF_FFFF) tcyc <= tcyc + 32'd1;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_spurious", 1, 0);
                end else begin
                    mon_e = rsp_q.pop_front();
                    check("rsp_data", rsp_rdata, mon_e.data);
                    check("rsp_latency", ecnt, mon_e.edge_no);
                end
            end
            if (con_valid && con_ready) begin
                if (con_q.size() == 0) check("con_spurious", 1, 0);
                else check("con_data", con_data, con_q.pop_front());
            end
        end
    end

    task automatic bus(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp,
                       input bit use_cyc = 1'b0);
        rsp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready) begin
                e.data    = use_cyc ? tcyc : exp;
                e.edge_no = ecnt + 1;
                rsp_q.push_back(e);
                if (we && addr == BASE + 32'h4) con_q.push_back(wdata[7:0]);
                @(posedge clk);
                #1;
                return;
            end
        end
        check("req_accept_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done) return;
        end
        check(tag, 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        con_ready = 1'b0;
        rsp_q.delete();
        con_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_flags", {req_ready, rsp_valid, con_valid, done, pass,
                            timeout}, 6'b100000);
        check("rst_vals", {rsp_rdata, con_data, exit_code}, 0);
        check("rst_cycles", cycles, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // exit with code 0 at cycle 20, then sticky exit and bus reads
        do_reset();
        repeat (18) @(posedge clk);
        #1;
        bus(1, BASE, 32'h1, 0);
        idle();
        wait_done(20, "t1_done_timeout");
        check("t1_flags", {done, pass, timeout}, 3'b110);
        check("t1_code", exit_code, 0);
        @(posedge clk);
        #1;
        bus(0, BASE, 0, 32'h1);
        bus(1, BASE, 32'hFF, 0);
        bus(0, BASE, 0, 32'hFF);
        idle();
        @(posedge clk);
        #1;
        check("t1_sticky", {pass, exit_code}, {1'b1, 31'd0});
        bus(0, BASE + 32'h8, 0, 0, 1'b1);
        bus(0, BASE + 32'hC, 0, 32'h3);
        bus(0, BASE + 32'h20, 0, 32'hDEAD_BEEF);
        bus(1, BASE + 32'h24, 32'h5, 0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("t5_rsp_drained", rsp_q.size(), 0);

        // console drain before done, nonzero exit code
        do_reset();
        bus(1, BASE + 32'h4, 32'h48, 0);
        bus(1, BASE + 32'h4, 32'h69, 0);
        bus(1, BASE, 32'h7, 0);
        idle();
        repeat (30) @(posedge clk);
        #1;
        check("t2_no_done", {done, con_valid}, 2'b01);
        bus(0, BASE + 32'h4, 0, 32'(DEPTH - 2));
        idle();
        con_ready = 1'b1;
        wait_done(50, "t2_done_timeout");
        check("t2_flags", {done, pass, timeout, con_valid}, 4'b1000);
        check("t2_code", exit_code, 3);
        check("t2_con_drained", con_q.size(), 0);
        @(posedge clk);
        #1;

        // full FIFO stalls the ninth console write
        do_reset();
        for (int i = 0; i < DEPTH; i++) bus(1, BASE + 32'h4, 32'h30 + i, 0);
        bus(0, BASE + 32'h4, 0, 0);
        bus(0, BASE + 32'hC, 0, 32'h4);
        fork
            begin
                bus(1, BASE + 32'h4, 32'h39, 0);
                idle();
                con_ready = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                check("t3_stall", req_ready, 0);
                @(posedge clk);
                #1;
                con_ready = 1'b1;
            end
        join
        bus(0, BASE + 32'hC, 0, 32'h0);
        bus(0, BASE + 32'h4, 0, 32'(DEPTH - con_q.size()));
        idle();
        con_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("t3_drained", {con_valid, 1'b0}, 2'b00);
        check("t3_con_q", con_q.size(), 0);

        // asynchronous reset during drain
        do_reset();
        for (int i = 0; i < 3; i++) bus(1, BASE + 32'h4, 32'h61 + i, 0);
        bus(1, BASE, 32'h1, 0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("t6_draining", {con_valid, done}, 2'b10);
        #2;
        rst = 1'b1;
        rsp_q.delete();
        con_q.delete();
        #1;
        check("t6_rst_flags", {req_ready, rsp_valid, con_valid, done, pass,
                               timeout}, 6'b100000);
        check("t6_rst_vals", {cycles, con_data, exit_code}, 0);

        // idle core until the hang timeout
        do_reset();
        wait_done(TMO + 100, "t4_done_timeout");
        check("t4_cycles", cycles, TMO - 1);
        check("t4_flags", {done, pass, timeout}, 3'b101);
        @(posedge clk);
        #1;
        bus(0, BASE + 32'hC, 0, 32'hB);
        bus(1, BASE, 32'h1, 0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("t4_sticky", {pass, timeout, exit_code}, {2'b01, 31'd0});
        check("final_rsp_q", rsp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
